// File: rtl/i2c_target_regs.sv
// I2C target serving a byte-wide register bank with an auto-incrementing pointer.
// SCL/SDA are synchronized and glitch-filtered; all protocol decoding runs on the
// filtered lines. SDA is only ever changed on the cycle after a filtered SCL fall,
// or released by STOP/START/reset.
module i2c_target_regs #(
    parameter logic [6:0]  I2C_ADDR   = 7'h50,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned FILTER_LEN = 3,
    localparam int unsigned PW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_low_n,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_pulse,
    output logic [PW-1:0]         wr_index,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } state_e;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]    meta_q, sync_q, filt_q, filt_d, prev_q;
    logic [CW-1:0] fcnt_q [2];
    logic [CW-1:0] fcnt_d [2];

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_low_n_q, sda_low_n_d;
    logic          busy_q, busy_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [PW-1:0] wr_index_q, wr_index_d;
    logic [7:0]    regs_q [NUM_REGS];

    logic          wr_en;
    logic          scl_f, sda_f, scl_p, sda_p;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]    byte_in;
    logic [PW-1:0] ptr_inc;

    // Synchronizer, glitch filter and previous-level registers for edge detection.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            meta_q    <= 2'b11;
            sync_q    <= 2'b11;
            filt_q    <= 2'b11;
            prev_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            meta_q    <= {sda_in, scl_in};
            sync_q    <= meta_q;
            filt_q    <= filt_d;
            prev_q    <= filt_q;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
        end
    end

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (sync_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_p     = prev_q[0];
    assign sda_p     = prev_q[1];
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
    assign byte_in   = {sh_q[6:0], sda_f};
    assign ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);

    // Protocol state, pointer, SDA drive and register bank.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            sda_low_n_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_index_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            sda_low_n_q <= sda_low_n_d;
            busy_q      <= busy_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_index_q  <= wr_index_d;
            if (wr_en) begin
                regs_q[ptr_q] <= byte_in;
            end
        end
    end

    // Next-state logic; START/STOP take priority over any bit handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        sda_low_n_d = sda_low_n_q;
        busy_d      = busy_q;
        wr_pulse_d  = 1'b0;
        wr_index_d  = wr_index_q;
        wr_en       = 1'b0;

        if (stop_det) begin
            state_d     = StIdle;
            cnt_d       = '0;
            sda_low_n_d = 1'b1;
            busy_d      = 1'b0;
        end else if (start_det) begin
            state_d     = StAddr;
            cnt_d       = '0;
            sda_low_n_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            // Address 0 (general call) never matches.
                            if (byte_in[7:1] == I2C_ADDR && I2C_ADDR != 7'd0) begin
                                state_d = StAddrAck;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = StIgnore;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    // First fall drives ACK, second fall ends it; sh_q[0] holds R/W.
                    if (scl_fall) begin
                        if (sda_low_n_q) begin
                            sda_low_n_d = 1'b0;
                        end else if (sh_q[0]) begin
                            sh_d        = {regs_q[ptr_q][6:0], 1'b0};
                            sda_low_n_d = regs_q[ptr_q][7];
                            cnt_d       = 4'd1;
                            state_d     = StRdData;
                        end else begin
                            sda_low_n_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = StPtr;
                        end
                    end
                end
                StPtr: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (32'(byte_in) < NUM_REGS) begin
                                ptr_d   = byte_in[PW-1:0];
                                state_d = StPtrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StPtrAck, StWrAck: begin
                    if (scl_fall) begin
                        if (sda_low_n_q) begin
                            sda_low_n_d = 1'b0;
                        end else begin
                            sda_low_n_d = 1'b1;
                            cnt_d       = '0;
                            state_d     = StWrData;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d      = '0;
                            wr_en      = 1'b1;
                            wr_pulse_d = 1'b1;
                            wr_index_d = ptr_q;
                            ptr_d      = ptr_inc;
                            state_d    = StWrAck;
                        end
                    end
                end
                StRdData: begin
                    // cnt_q counts bits already presented; the fall after bit 0 releases.
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_low_n_d = 1'b1;
                            state_d     = StRdAck;
                        end else begin
                            sda_low_n_d = sh_q[7];
                            sh_d        = {sh_q[6:0], 1'b0};
                            cnt_d       = cnt_q + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            ptr_d   = ptr_inc;
                            sh_d    = regs_q[ptr_inc];
                            cnt_d   = '0;
                            state_d = StRdData;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Flatten the bank for fabric consumers.
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*8 +: 8] = regs_q[i];
        end
    end

    assign sda_low_n = sda_low_n_q;
    assign busy      = busy_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master drives the bus, a transaction-level
// register model predicts write strobes and read data, and a monitor pops expected
// write strobes from a queue whenever wr_pulse fires.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int         NREG = 16;
    localparam int         Q    = 12;
    localparam logic [6:0] ADDR = 7'h50;

    typedef struct {
        int       idx;
        bit [7:0] data;
    } exp_t;

    logic                axi_aclk = 1'b0;
    logic                axi_aresetn = 1'b0;
    logic                scl_m = 1'b1;
    logic                sda_m = 1'b1;
    logic                scl_in, sda_in, sda_low_n, wr_pulse, busy;
    logic [NREG*8-1:0]   regs_o;
    logic [3:0]          wr_index;

    assign scl_in = scl_m;
    assign sda_in = sda_m & sda_low_n;

    i2c_target_regs dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_low_n   (sda_low_n),
        .regs_o      (regs_o),
        .wr_pulse    (wr_pulse),
        .wr_index    (wr_index),
        .busy        (busy)
    );

    always #5 axi_aclk = ~axi_aclk;

    int       n_checks = 0;
    int       n_err = 0;
    int       hold_err = 0;
    bit       mon_en = 1'b0;
    logic     last_sda = 1'b1;
    bit [7:0] m_regs [NREG];
    int       m_ptr = 0;
    exp_t     exp_q [$];
    exp_t     e;
    bit [7:0] wq [$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(posedge axi_aclk) begin
        #1;
        if (mon_en) begin
            if (wr_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_pulse", int'(wr_pulse), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_index", int'(wr_index), e.idx);
                    check("wr_data", int'(regs_o[e.idx*8 +: 8]), int'(e.data));
                end
            end
            if (sda_low_n !== last_sda && scl_in) hold_err++;
        end
        last_sda = sda_low_n;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge axi_aclk);
    endtask

    task automatic write_bit(input bit b);
        sda_m = b;  tick(Q);
        scl_m = 1;  tick(Q);
        scl_m = 0;  tick(Q);
    endtask

    task automatic read_bit(output bit v);
        sda_m = 1;  tick(Q);
        scl_m = 1;  tick(Q / 2);
        v = sda_m & sda_low_n;
        tick(Q - Q / 2);
        scl_m = 0;  tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1;  tick(Q);
        scl_m = 1;  tick(Q);
        sda_m = 0;  tick(Q);
        scl_m = 0;  tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 0;  tick(Q);
        scl_m = 1;  tick(Q);
        sda_m = 1;  tick(Q);
    endtask

    task automatic send_byte(input bit [7:0] b, output bit ack_line);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack_line);
    endtask

    task automatic read_byte(output bit [7:0] v);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    // Write transaction with data bytes taken from wq.
    task automatic do_write(input bit [6:0] addr, input int p);
        bit a;
        bit match;
        bit pok;
        match = (addr == ADDR);
        i2c_start();
        send_byte({addr, 1'b0}, a);
        check("addr_ack", int'(a), match ? 0 : 1);
        if (!match) begin
            check("busy_after_bad_addr", int'(busy), 0);
            i2c_stop();
            return;
        end
        check("busy_in_xfer", int'(busy), 1);
        pok = (p < NREG);
        send_byte(8'(p), a);
        check("ptr_ack", int'(a), pok ? 0 : 1);
        if (pok) m_ptr = p;
        foreach (wq[i]) begin
            if (pok) begin
                exp_q.push_back('{idx: m_ptr, data: wq[i]});
                m_regs[m_ptr] = wq[i];
                m_ptr = (m_ptr + 1) % NREG;
            end
            send_byte(wq[i], a);
            check("data_ack", int'(a), pok ? 0 : 1);
        end
        i2c_stop();
        check("busy_after_stop", int'(busy), 0);
    endtask

    // Random-address read: set pointer, repeated START, read n bytes, NACK the last.
    task automatic do_read(input int p, input int n);
        bit       a;
        bit [7:0] v;
        i2c_start();
        send_byte({ADDR, 1'b0}, a);
        check("rd_addr_w_ack", int'(a), 0);
        send_byte(8'(p), a);
        check("rd_ptr_ack", int'(a), 0);
        m_ptr = p;
        i2c_start();
        send_byte({ADDR, 1'b1}, a);
        check("rd_addr_r_ack", int'(a), 0);
        for (int k = 0; k < n; k++) begin
            read_byte(v);
            check("rd_data", int'(v), int'(m_regs[m_ptr]));
            if (k < n - 1) begin
                write_bit(1'b0);
                m_ptr = (m_ptr + 1) % NREG;
            end else begin
                read_bit(a);
                check("rd_last_released", int'(a), 1);
            end
        end
        i2c_stop();
        check("busy_after_rd_stop", int'(busy), 0);
    endtask

    initial begin
        bit        a;
        bit [6:0]  addr;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;

        // Reset state
        tick(4);
        check("rst_sda_low_n", int'(sda_low_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_pulse", int'(wr_pulse), 0);
        check("rst_wr_index", int'(wr_index), 0);
        check("rst_regs_zero", int'(regs_o != '0), 0);
        axi_aresetn = 1;
        tick(10);
        mon_en = 1;

        // Directed write, read, wrap
        wq = '{8'h11, 8'h22};
        do_write(ADDR, 2);
        do_read(3, 2);
        wq = '{8'hAA, 8'hBB};
        do_write(ADDR, 15);

        // Address and pointer rejection
        wq = '{};
        do_write(7'h51, 0);
        wq = '{8'h55};
        do_write(ADDR, 16);

        // 1-cycle SDA glitch while SCL high must not look like a START
        tick(Q);
        sda_m = 0;  tick(1);
        sda_m = 1;  tick(Q);
        scl_m = 0;  tick(Q);
        send_byte({ADDR, 1'b0}, a);
        check("glitch_no_ack", int'(a), 1);
        check("glitch_busy", int'(busy), 0);
        i2c_stop();

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                addr = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
                wq = '{};
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) wq.push_back(8'($urandom));
                do_write(addr, int'($urandom_range(0, 19)));
            end else begin
                do_read(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
            end
        end

        // Reset while the target drives a 0 data bit
        wq = '{8'h3C};
        do_write(ADDR, 5);
        i2c_start();
        send_byte({ADDR, 1'b0}, a);
        send_byte(8'd5, a);
        i2c_start();
        send_byte({ADDR, 1'b1}, a);
        check("rd_addr_ack_pre_rst", int'(a), 0);
        check("driving_bit7_low", int'(sda_low_n), 0);
        axi_aresetn = 0;
        @(posedge axi_aclk);
        #1;
        check("midrst_sda_low_n", int'(sda_low_n), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_regs_zero", int'(regs_o != '0), 0);
        tick(2);
        sda_m = 1;
        scl_m = 1;
        tick(2);
        axi_aresetn = 1;
        tick(10);
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_ptr = 0;
        wq = '{8'h5A};
        do_write(ADDR, 7);
        do_read(6, 2);

        // Final state against the model
        tick(10);
        for (int i = 0; i < NREG; i++) begin
            check("final_reg", int'(regs_o[i*8 +: 8]), int'(m_regs[i]));
        end
        check("pending_writes", exp_q.size(), 0);
        check("sda_change_while_scl_high", hold_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (responder) for the on-board I2C bus that the RISC-V CPU masters by bit-banging its GPIOs. It decodes START/STOP, matches a 7-bit device address, and serves a byte-wide register bank with an auto-incrementing pointer. Written bytes are exposed to fabric logic; reads return bank contents. It sits on the axi_aclk domain beside the CPU and shares the open-drain SDA line.

Parameters:
I2C_ADDR, 7'h50, 7-bit target address matched after START.
NUM_REGS, 16, number of 8-bit registers; pointer width PW = clog2(NUM_REGS).
FILTER_LEN, 3, consecutive equal synchronized samples required to accept a new SCL/SDA level.

Ports:
axi_aclk  input  1  clock; 50 MHz fabric clock.
axi_aresetn  input  1  reset; synchronous and active-low.
scl_in  input  1  raw bus SCL (asynchronous).
sda_in  input  1  raw bus SDA (asynchronous).
sda_low_n  output  1  0 = pull SDA low; 1 = release.
regs_o  output  NUM_REGS*8  flattened register bank; reg i is regs_o[i*8+:8].
wr_pulse  output  1  one-cycle strobe per accepted write byte.
wr_index  output  PW  register index written, valid with wr_pulse.
busy  output  1  high from address match until STOP or NACKed address.

Behaviour:
- Reset (axi_aresetn=0 at clock edge): sda_low_n=1, regs_o=0, wr_pulse=0, wr_index=0, busy=0, pointer=0, FSM=IDLE. Reset mid-transfer releases SDA on the next edge. Filters reset to 1.
- Input path: 2-flop synchronizer, then FILTER_LEN glitch filter per line. Edge detects run on the filtered lines. Bus is sampled on SCL rising edge and driven after SCL falling edge.
- START: SDA falls while SCL is high. Enters ADDR from any state, including repeated START. Pointer is kept.
- STOP: SDA rises while SCL is high. Enters IDLE from any state, with sda_low_n=1 and busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. Match is bits[7:1]==I2C_ADDR.
    - Match: go to ADDR_ACK, busy=1.
    - No match: go to IGNORE.
  - ADDR_ACK: drive SDA low from the SCL falling edge after bit 8 until the falling edge after the 9th clock.
    - R/W=0: go to PTR.
    - R/W=1: load shift register with reg[pointer], go to RD_DATA.
  - PTR: receive 8 bits.
    - Value < NUM_REGS: pointer=value, ACK, go to WR_DATA.
    - Otherwise: NACK (SDA released), go to IGNORE.
  - WR_DATA: receive 8 bits, then ACK.
    - On the 8th SCL rising edge: reg[pointer]<=byte, wr_pulse=1 for one cycle with wr_index=pointer.
    - Pointer then increments mod NUM_REGS (wraps NUM_REGS-1 -> 0).
    - Stays in WR_DATA for further bytes.
  - RD_DATA: drive the shift register MSB first. Each bit is presented after an SCL falling edge: sda_low_n = bit. After 8 bits, release SDA.
  - RD_ACK: sample SDA on the 9th SCL rising edge.
    - 0 (ACK): pointer increments mod NUM_REGS, load the next byte, return to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Drive timing: SDA is updated on the first cycle after a detected filtered SCL falling edge. This gives ≥ (2+FILTER_LEN) cycles of hold. SDA never changes while filtered SCL is high, except on release by STOP/reset.
- Simultaneous events:
  - A START/STOP detected in the same cycle as an SCL edge wins over data handling.
  - A write byte aborted by START/STOP before its 8th rising edge is discarded; no wr_pulse is issued.
- General call (address 0) is not supported and is treated as no match.

Test Plan:
- Write: START, 0xA0, ptr 0x02, data 0x11, 0x22, STOP -> all 4 bytes ACKed; reg2=0x11, reg3=0x22; two wr_pulse with wr_index 2 then 3; busy low after STOP.
- Random read: START, 0xA0, ptr 0x03, repeated START, 0xA1, read 2 bytes (ACK, then NACK), STOP -> returns 0x22 then reg4=0x00; SDA released at the 9th clock of the last byte.
- Wrap: write ptr 0x0F, data 0xAA, 0xBB -> reg15=0xAA, reg0=0xBB; wr_index 15 then 0.
- Address/pointer rejection: START, 0xA2 -> SDA stays 1 during the 9th clock, busy=0, no wr_pulse. Valid address with ptr 0x10 -> ptr NACKed, following data ignored.
- Glitch/hold: inject a 1-cycle SDA low pulse while SCL is high -> no START detected. Check sda_low_n never toggles while filtered SCL=1 during a full read.
- Reset mid-read: assert axi_aresetn=0 while target drives SDA low -> next edge sda_low_n=1, regs_o=0, busy=0. A subsequent transaction works normally.
